// File: rtl/decoder_scan.sv
// decoder_scan: registered address decoder with an auto-scan mode.
//
// Direct mode (en=1, mode=0) drives the line selected by add. Scan mode
// (en=1, mode=1) walks through every output line. Each line stays selected
// for dwell+1 cycles. en=0 forces all lines inactive and clears scan progress.
//
// Parameters
//   ADDR_W  : address width (1..6); output width is 2**ADDR_W
//   DWELL_W : width of the dwell input and of the dwell counter
//   ACT_LOW : 1 = selected line driven 0, others 1; 0 = inverted polarity
//
// Ports
//   sys_clk   : single clock, all state updates on its rising edge
//   sys_rst_n : synchronous active-low reset
//   en        : block enable
//   mode      : 0 = direct decode of add, 1 = auto-scan
//   add       : line to select in direct mode
//   dwell     : scan mode hold time, in cycles minus one
//   dout      : registered decoded output
//   cur_idx   : registered index of the selected line, 0 when idle
//   wrap      : registered pulse when the scan returns to line 0
module decoder_scan #(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 16,
    parameter int ACT_LOW = 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [ADDR_W-1:0]      add,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [2**ADDR_W-1:0]   dout,
    output logic [ADDR_W-1:0]      cur_idx,
    output logic                   wrap
);

    localparam int OUT_W = 2 ** ADDR_W;
    localparam logic [OUT_W-1:0] INACTIVE = (ACT_LOW != 0) ? '1 : '0;

    logic [OUT_W-1:0]   dout_q,     dout_d;
    logic [ADDR_W-1:0]  cur_idx_q,  cur_idx_d;
    logic               wrap_q,     wrap_d;
    logic [ADDR_W-1:0]  scan_idx_q, scan_idx_d;
    logic [DWELL_W-1:0] cnt_q,      cnt_d;
    // Set on the advance from the last line, so that wrap rises together
    // with line 0 appearing on dout one cycle later.
    logic               wrap_arm_q, wrap_arm_d;

    function automatic logic [OUT_W-1:0] line_pattern(input logic [ADDR_W-1:0] idx);
        logic [OUT_W-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return (ACT_LOW != 0) ? ~onehot : onehot;
    endfunction

    always_comb begin
        dout_d     = INACTIVE;
        cur_idx_d  = '0;
        wrap_d     = 1'b0;
        scan_idx_d = '0;
        cnt_d      = '0;
        wrap_arm_d = 1'b0;
        if (en) begin
            if (!mode) begin
                dout_d    = line_pattern(add);
                cur_idx_d = add;
            end else begin
                dout_d    = line_pattern(scan_idx_q);
                cur_idx_d = scan_idx_q;
                wrap_d    = wrap_arm_q;
                // >= against the live dwell value: lowering dwell below the
                // current count advances at once instead of wrapping cnt.
                if (cnt_q >= dwell) begin
                    // Index width is exactly ADDR_W, so +1 wraps modulo OUT_W.
                    scan_idx_d = scan_idx_q + ADDR_W'(1);
                    wrap_arm_d = (scan_idx_q == '1);
                end else begin
                    scan_idx_d = scan_idx_q;
                    cnt_d      = cnt_q + DWELL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dout_q     <= INACTIVE;
            cur_idx_q  <= '0;
            wrap_q     <= 1'b0;
            scan_idx_q <= '0;
            cnt_q      <= '0;
            wrap_arm_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            cur_idx_q  <= cur_idx_d;
            wrap_q     <= wrap_d;
            scan_idx_q <= scan_idx_d;
            cnt_q      <= cnt_d;
            wrap_arm_q <= wrap_arm_d;
        end
    end

    assign dout    = dout_q;
    assign cur_idx = cur_idx_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed and randomized checks of decoder_scan.
// u_dut uses the default parameters (8 lines, active-low outputs).
// u_dut2 uses ADDR_W=2, DWELL_W=4, ACT_LOW=0 (4 lines, active-high outputs).
// The reference model treats a scan episode as elapsed time t since entry:
// line = (t / (dwell+1)) mod lines, wrap when t is a nonzero multiple of
// the full scan period.
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst_n, en, mode;
    logic [2:0]  add;
    logic [15:0] dwell;
    logic [7:0]  dout;
    logic [2:0]  cur_idx;
    logic        wrap;

    logic        rst2_n, en2, mode2;
    logic [1:0]  add2;
    logic [3:0]  dwell2;
    logic [3:0]  dout2;
    logic [1:0]  cur_idx2;
    logic        wrap2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned t1 = 0;
    int unsigned wraps;

    always #5 clk = ~clk;

    decoder_scan u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .mode(mode),
        .add(add), .dwell(dwell), .dout(dout), .cur_idx(cur_idx), .wrap(wrap)
    );

    decoder_scan #(.ADDR_W(2), .DWELL_W(4), .ACT_LOW(0)) u_dut2 (
        .sys_clk(clk), .sys_rst_n(rst2_n), .en(en2), .mode(mode2),
        .add(add2), .dwell(dwell2), .dout(dout2), .cur_idx(cur_idx2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active-low 8-line pattern: all ones when idle, bit k cleared when active.
    function automatic logic [7:0] exp8(input bit act, input int unsigned k);
        logic [7:0] v;
        v = '0;
        if (act) v[k % 8] = 1'b1;
        return ~v;
    endfunction

    function automatic logic [3:0] exp4(input int unsigned k);
        logic [3:0] v;
        v = '0;
        v[k % 4] = 1'b1;
        return v;
    endfunction

    // One clock edge; the model predicts u_dut outputs from the inputs that
    // were sampled at that edge.
    task automatic step1(input bit use_model);
        logic [7:0]  e_d;
        logic [2:0]  e_i;
        logic        e_w;
        int unsigned k, per;
        @(posedge clk);
        #1;
        if (!rst_n || !en) begin
            e_d = exp8(0, 0); e_i = 3'd0; e_w = 1'b0; t1 = 0;
        end else if (!mode) begin
            e_d = exp8(1, add); e_i = add; e_w = 1'b0; t1 = 0;
        end else begin
            per = int'(dwell) + 1;
            k   = (t1 / per) % 8;
            e_d = exp8(1, k); e_i = 3'(k);
            e_w = (t1 != 0) && (t1 % (8 * per) == 0);
            t1++;
        end
        if (use_model) begin
            chk("model_dout", 64'(dout), 64'(e_d));
            chk("model_cur_idx", 64'(cur_idx), 64'(e_i));
            chk("model_wrap", 64'(wrap), 64'(e_w));
        end
    endtask

    initial begin
        logic [7:0] legacy [8];
        legacy = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        rst_n = 1'b0; en = 1'b1; mode = 1'b1; add = 3'd5; dwell = 16'd0;
        rst2_n = 1'b0; en2 = 1'b0; mode2 = 1'b0; add2 = 2'd0; dwell2 = 4'd0;

        // Reset takes priority over en/mode.
        step1(1);
        step1(1);
        chk("reset_dout", 64'(dout), 64'hFF);
        chk("reset_cur_idx", 64'(cur_idx), 64'd0);
        chk("reset_wrap", 64'(wrap), 64'd0);
        chk("reset2_dout", 64'(dout2), 64'h0);
        rst_n = 1'b1; rst2_n = 1'b1;
        en = 1'b0;
        step1(1);

        // Legacy 3-8 active-low truth table, one cycle latency.
        en = 1'b1; mode = 1'b0;
        for (int a = 0; a < 8; a++) begin
            add = 3'(a);
            step1(1);
            chk("legacy_dout", 64'(dout), 64'(legacy[a]));
            chk("legacy_idx", 64'(cur_idx), 64'(a));
        end

        // Scan dwell=2: 3 cycles per line, wrap every 24 cycles.
        en = 1'b0; step1(1);
        en = 1'b1; mode = 1'b1; dwell = 16'd2; wraps = 0;
        for (int s = 0; s < 49; s++) begin
            step1(1);
            if (s == 24) chk("dwell2_line0_at_wrap", 64'(dout), 64'hFE);
            if (wrap) wraps++;
        end
        chk("dwell2_wrap_count", 64'(wraps), 64'd2);

        // Scan dwell=0: rotate every cycle, wrap one cycle in eight.
        en = 1'b0; step1(1);
        en = 1'b1; dwell = 16'd0; wraps = 0;
        for (int s = 0; s < 17; s++) begin
            step1(1);
            if (wrap) wraps++;
        end
        chk("dwell0_wrap_count", 64'(wraps), 64'd2);

        // Drop en mid-dwell of line 5, then restart at line 0.
        en = 1'b0; step1(1);
        en = 1'b1; dwell = 16'd2;
        for (int s = 0; s < 16; s++) step1(1);
        chk("pre_drop_line5", 64'(dout), 64'hDF);
        en = 1'b0; step1(1);
        chk("en_drop_dout", 64'(dout), 64'hFF);
        en = 1'b1; step1(1);
        chk("restart_dout", 64'(dout), 64'hFE);
        chk("restart_idx", 64'(cur_idx), 64'd0);

        // Reset mid-scan, then a full dwell on line 0.
        dwell = 16'd3;
        for (int s = 0; s < 9; s++) step1(1);
        rst_n = 1'b0; step1(1);
        chk("midscan_rst_dout", 64'(dout), 64'hFF);
        chk("midscan_rst_wrap", 64'(wrap), 64'd0);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step1(1);
            chk("post_rst_line0", 64'(dout), 64'hFE);
        end
        step1(1);
        chk("post_rst_line1", 64'(dout), 64'hFD);

        // Dwell lowered below the running count advances on the next edge.
        en = 1'b0; step1(1);
        en = 1'b1; dwell = 16'd5;
        for (int s = 0; s < 3; s++) step1(1);
        dwell = 16'd1;
        step1(0); chk("lower_dwell_e1", 64'(dout), 64'hFE);
        step1(0); chk("lower_dwell_e2", 64'(dout), 64'hFD);
        step1(0); chk("lower_dwell_e3", 64'(dout), 64'hFD);
        step1(0); chk("lower_dwell_e4", 64'(dout), 64'hFB);

        // Scan to direct: line add next cycle, no wrap.
        mode = 1'b0; add = 3'd6; step1(1);
        chk("scan_to_direct", 64'(dout), 64'hBF);
        en = 1'b0; step1(1);

        // Second configuration: 4 active-high lines.
        en2 = 1'b1; mode2 = 1'b0; add2 = 2'd2;
        step1(1);
        chk("cfg2_direct_dout", 64'(dout2), 64'h4);
        chk("cfg2_direct_idx", 64'(cur_idx2), 64'd2);
        mode2 = 1'b1; dwell2 = 4'd9;
        for (int s = 0; s < 41; s++) begin
            step1(1);
            chk("cfg2_dwell9_dout", 64'(dout2), 64'(exp4(s / 10)));
            chk("cfg2_dwell9_wrap", 64'(wrap2), 64'(s == 40));
        end
        en2 = 1'b0; step1(1);
        chk("cfg2_disabled", 64'(dout2), 64'h0);
        // All-ones dwell: 16 cycles per line.
        en2 = 1'b1; dwell2 = 4'hF;
        for (int s = 0; s < 17; s++) begin
            step1(1);
            chk("cfg2_dwell_max", 64'(dout2), 64'(exp4(s / 16)));
        end
        en2 = 1'b0;

        // Randomized traffic; dwell only changes outside scan episodes.
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) >= 3);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            add   = 3'($urandom);
            if (!(rst_n && en && mode)) dwell = 16'($urandom_range(0, 3));
            step1(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter ADDR_W, default 3: address width; output width is OUT_W = 2**ADDR_W; legal range 1..6.
REQ-002 Parameter DWELL_W, default 16: dwell counter width in scan mode.
REQ-003 Parameter ACT_LOW, default 1: 1 = selected output line driven 0 and others 1; 0 = inverted polarity.
REQ-004 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 sys_rst_n  in  1  synchronous, active-low reset, sampled on the sys_clk rising edge.
REQ-006 en  in  1  block enable; 0 forces all outputs inactive.
REQ-007 mode  in  1  0 = direct decode of add; 1 = auto-scan through all outputs.
REQ-008 add  in  ADDR_W  line to select in direct mode; ignored in scan mode.
REQ-009 dwell  in  DWELL_W  scan mode only: each line stays selected for dwell+1 cycles.
REQ-010 dout  out  OUT_W  registered one-hot (one-cold if ACT_LOW=1) decoded output.
REQ-011 cur_idx  out  ADDR_W  registered index of the line currently selected; 0 when idle.
REQ-012 wrap  out  1  registered one-cycle pulse when the scan index wraps from OUT_W-1 to 0.

Function
REQ-013 All outputs are registered; dout and cur_idx reflect inputs sampled on the previous rising edge (latency 1 cycle).
REQ-014 "Inactive" dout is all ones when ACT_LOW=1 and all zeros when ACT_LOW=0; "line k active" is inactive with bit k inverted.
REQ-015 en=0: next cycle dout inactive, cur_idx=0, wrap=0, scan index and dwell counter cleared to 0; mode, add and dwell ignored.
REQ-016 Direct state (en=1, mode=0): next cycle line add active, cur_idx=add, wrap=0; dwell counter held at 0.
REQ-017 Scan state (en=1, mode=1): line scan_idx active, cur_idx=scan_idx; dwell counter cnt increments every cycle.
REQ-018 Scan advance: when cnt >= dwell (live value), cnt<=0 and scan_idx<=scan_idx+1 modulo OUT_W; otherwise cnt<=cnt+1.
REQ-019 dwell=0 advances scan_idx every cycle; dwell=all-ones gives 2**DWELL_W cycles per line; cnt never overflows.
REQ-020 dwell lowered mid-dwell below cnt: the >= compare advances on the next cycle; no wrap-around of cnt.
REQ-021 wrap=1 for exactly the one cycle after an advance from scan_idx=OUT_W-1 to 0; 0 at all other times.
REQ-022 Entry into scan from direct or disabled always starts at scan_idx=0, cnt=0; the first line 0 dwell lasts dwell+1 cycles.
REQ-023 Scan to direct: next cycle shows line add; scan_idx and cnt cleared; no wrap pulse.
REQ-024 Exactly one line is active whenever en=1 was sampled; never zero or multiple lines active when enabled.
REQ-025 ADDR_W=3, ACT_LOW=1, mode=0 reproduces the legacy 3-8 active-low decoder truth table with one cycle delay.

Reset
REQ-026 sys_rst_n=0 at a rising edge: dout inactive, cur_idx=0, wrap=0, scan_idx=0, cnt=0 after that edge, taking priority over en and mode.
REQ-027 Reset asserted mid-scan or mid-dwell discards scan progress; the first scan after reset release starts at line 0 with a full dwell.
REQ-028 No output changes except on a sys_clk rising edge; reset has no asynchronous path.

Verification
REQ-029 Reset, then en=1, mode=0, sweep add 0..7 (defaults) -> dout 8'hFE,FD,FB,F7,EF,DF,BF,7F each one cycle after add, cur_idx=add.
REQ-030 en=1, mode=1, dwell=2 -> lines 0..7 each active 3 cycles, wrap pulses once every 24 cycles, on the cycle line 0 reappears.
REQ-031 Scan with dwell=0 -> dout rotates every cycle; wrap high one cycle in eight.
REQ-032 Mid-scan, line 5 with cnt=1, drop en for 1 cycle -> dout=8'hFF next cycle; after en=1, scan restarts at line 0, dout=8'hFE.
REQ-033 Mid-scan, assert sys_rst_n=0 for one edge -> dout=8'hFF, wrap=0 after that edge; after release, line 0 active for dwell+1 cycles.
REQ-034 ACT_LOW=0, ADDR_W=2, mode=0, add=2 -> dout=4'b0100; mode=1, dwell=9 -> 10-cycle dwell per line, wrap every 40 cycles.
